alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 30 +++
 rtl/alu_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response and external-ALU signals of the ALU sequencer.
// The master modport is the requester side (which also hosts the external ALU); the slave modport is the sequencer.
interface alu_sequencer_if;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_SIG;
    logic [31:0] alu_dataOut;
    logic        alu_Zero;
    logic        busy;
    logic        done;
    logic        err;
    logic        zero;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, funct, srcA, srcB, alu_dataOut, alu_Zero,
        input  alu_A, alu_B, alu_SIG, busy, done, err, zero, result, hi, lo
    );

    modport slave (
        input  start, funct, srcA, srcB, alu_dataOut, alu_Zero,
        output alu_A, alu_B, alu_SIG, busy, done, err, zero, result, hi, lo
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences single-cycle R-type ops and a 32-step shift-add MULTU through an external 32-bit ALU.
// The MULTU multiplier lives in lo and shifts out as the product shifts in.
module alu_sequencer (
    input logic            clk,
    input logic            rst,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] op_a, op_b, hi_q, lo_q, result_q;
    logic [2:0]  sig_q;
    logic [4:0]  count;
    logic        err_q, zero_q;
    logic [2:0]  dec_sig;
    logic        dec_mul, dec_legal;
    logic [31:0] mul_sum;
    logic        mul_carry;
    logic [63:0] mul_next;

    always_comb begin
        dec_sig   = 3'b010;
        dec_mul   = 1'b0;
        dec_legal = 1'b1;
        case (bus.funct)
            6'b100100: dec_sig = 3'b000;
            6'b100101: dec_sig = 3'b001;
            6'b100000: dec_sig = 3'b010;
            6'b100010: dec_sig = 3'b110;
            6'b101010: dec_sig = 3'b111;
            6'b011001: dec_mul = 1'b1;
            default:   dec_legal = 1'b0;
        endcase
    end

    // Carry out of hi + multiplicand recovered from operand and sum MSBs.
    always_comb begin
        mul_sum   = lo_q[0] ? bus.alu_dataOut : hi_q;
        mul_carry = lo_q[0] & ((hi_q[31] & op_a[31]) | ((hi_q[31] | op_a[31]) & ~mul_sum[31]));
        mul_next  = {mul_carry, mul_sum, lo_q[31:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = !dec_legal ? DONE : (dec_mul ? MUL : EXEC);
            EXEC: state_next = DONE;
            MUL:  if (count == 5'd31) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            sig_q    <= 3'b010;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            count    <= '0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    err_q <= 1'b0;
                    if (!dec_legal) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                    end else if (dec_mul) begin
                        op_a  <= bus.srcA;
                        op_b  <= bus.srcB;
                        sig_q <= 3'b010;
                        hi_q  <= '0;
                        lo_q  <= bus.srcB;
                        count <= '0;
                    end else begin
                        op_a  <= bus.srcA;
                        op_b  <= bus.srcB;
                        sig_q <= dec_sig;
                    end
                end
                EXEC: begin
                    result_q <= bus.alu_dataOut;
                    zero_q   <= bus.alu_Zero;
                end
                MUL: begin
                    {hi_q, lo_q} <= mul_next;
                    count        <= count + 5'd1;
                    if (count == 5'd31) begin
                        result_q <= mul_next[31:0];
                        zero_q   <= (mul_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy    = (state != IDLE);
        bus.done    = (state == DONE);
        bus.alu_A   = '0;
        bus.alu_B   = '0;
        bus.alu_SIG = 3'b010;
        case (state)
            EXEC: begin
                bus.alu_A   = op_a;
                bus.alu_B   = op_b;
                bus.alu_SIG = sig_q;
            end
            MUL: begin
                bus.alu_A   = hi_q;
                bus.alu_B   = op_a;
                bus.alu_SIG = 3'b010;
            end
            default: ;
        endcase
        bus.result = result_q;
        bus.hi     = hi_q;
        bus.lo     = lo_q;
        bus.err    = err_q;
        bus.zero   = zero_q;
    end
endmodule
